// File: rtl/fft_reorder_pkg.sv
// rtl/fft_reorder_pkg.sv - shared lane count, FSM encodings and index helpers for the FFT reorder stage
package fft_reorder_pkg;

    localparam int LANES = 4;
    localparam int PW    = 10;

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_RUN}  rstate_t;

    function automatic logic [PW-1:0] bitrev(input logic [PW-1:0] p, input int log2n);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < PW; i++) begin
            if (i < log2n) r[log2n-1-i] = p[i];
        end
        return r;
    endfunction

    // At N=8 the top position bits overlap the lane bits, so the additive skew
    // collides; {p1, p0^p2} is conflict-free for both write and read beats there.
    function automatic logic [1:0] bank_sel(input logic [PW-1:0] p, input int log2n);
        if (log2n == 3) return {p[1], p[0] ^ p[2]};
        return 2'(p[1:0] + 2'(p >> (log2n - 2)));
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - simple dual-port RAM, synchronous write and synchronous read
module fft_reorder_bank #(
    parameter int W  = 38,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - bit-reversed to natural order frame reorder, ping-pong banked (optional FFT_REORDER_ERRFLAG_EN)
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int NBITS = 19,
    parameter int LOG2N = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [2*NBITS-1:0] fftIn0_up,
    input  logic [2*NBITS-1:0] fftIn0_down,
    input  logic [2*NBITS-1:0] fftIn1_up,
    input  logic [2*NBITS-1:0] fftIn1_down,
    output logic               out_valid,
    output logic               out_sof,
    output logic [2*NBITS-1:0] fftOut0_up,
    output logic [2*NBITS-1:0] fftOut0_down,
    output logic [2*NBITS-1:0] fftOut1_up,
    output logic [2*NBITS-1:0] fftOut1_down
`ifdef FFT_REORDER_ERRFLAG_EN
    ,
    output logic               err_sticky
`endif
);

    localparam int W  = 2 * NBITS;
    localparam int CW = LOG2N - 2;
    localparam int AW = LOG2N - 1;
    localparam int B  = 1 << CW;

    wstate_t       r_wstate;
    logic [CW-1:0] r_wc;
    logic          r_whalf;
    rstate_t       r_rstate;
    logic [CW-1:0] r_rc;
    logic          r_rhalf;
    logic          r_rv;
    logic          r_rsof;
    logic [1:0]    r_sel [LANES];

    logic [W-1:0]  w_in     [LANES];
    logic [AW-1:0] w_bwaddr [LANES];
    logic [W-1:0]  w_bwdata [LANES];
    logic [AW-1:0] w_braddr [LANES];
    logic [W-1:0]  w_rdata  [LANES];
    logic [1:0]    w_rsel   [LANES];
    logic [CW-1:0] w_wc;
    logic          w_we;
    logic          w_commit;
    logic [PW-1:0] w_wp;
    logic [PW-1:0] w_rp;
    logic [1:0]    w_wk;
    logic [1:0]    w_rk;

    assign w_in[0] = fftIn0_up;
    assign w_in[1] = fftIn0_down;
    assign w_in[2] = fftIn1_up;
    assign w_in[3] = fftIn1_down;

    // An in_sof beat always restarts at c=0; otherwise only W_FILL beats past c=0 are kept.
    always_comb begin
        w_wc     = in_sof ? '0 : r_wc;
        w_we     = in_valid && (in_sof || (r_wstate == W_FILL && r_wc != '0));
        w_commit = w_we && (w_wc == CW'(B - 1));
        w_wp     = '0;
        w_wk     = '0;
        for (int k = 0; k < LANES; k++) begin
            w_bwaddr[k] = '0;
            w_bwdata[k] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            w_wp           = PW'({w_wc, 2'(l)});
            w_wk           = bank_sel(w_wp, LOG2N);
            w_bwaddr[w_wk] = {r_whalf, w_wc};
            w_bwdata[w_wk] = w_in[l];
        end
    end

    always_comb begin
        w_rp = '0;
        w_rk = '0;
        for (int k = 0; k < LANES; k++) w_braddr[k] = '0;
        for (int l = 0; l < LANES; l++) begin
            w_rp           = bitrev(PW'({r_rc, 2'(l)}), LOG2N);
            w_rk           = bank_sel(w_rp, LOG2N);
            w_braddr[w_rk] = {r_rhalf, CW'(w_rp >> 2)};
            w_rsel[l]      = w_rk;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        fft_reorder_bank #(.W(W), .AW(AW)) u_bank (
            .clk     (clk),
            .i_we    (w_we),
            .i_waddr (w_bwaddr[g]),
            .i_wdata (w_bwdata[g]),
            .i_raddr (w_braddr[g]),
            .o_rdata (w_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wc     <= '0;
            r_whalf  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_we) begin
                    r_wstate <= W_FILL;
                    r_wc     <= w_wc + 1'b1;
                end
                W_FILL: if (w_we) begin
                    if (w_commit) begin
                        r_wc    <= '0;
                        r_whalf <= ~r_whalf;
                    end else begin
                        r_wc <= w_wc + 1'b1;
                    end
                end else if (in_valid) begin
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // The read side starts on the commit itself so the first bank read sees the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rc     <= '0;
            r_rhalf  <= 1'b0;
            r_rv     <= 1'b0;
            r_rsof   <= 1'b0;
            r_sel    <= '{default: '0};
        end else begin
            r_rv   <= (r_rstate == R_RUN);
            r_rsof <= (r_rstate == R_RUN) && (r_rc == '0);
            r_sel  <= w_rsel;
            if (w_commit) begin
                r_rstate <= R_RUN;
                r_rc     <= '0;
                r_rhalf  <= r_whalf;
            end else begin
                case (r_rstate)
                    R_RUN: begin
                        r_rc <= r_rc + 1'b1;
                        if (r_rc == CW'(B - 1)) r_rstate <= R_IDLE;
                    end
                    default: r_rstate <= R_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            fftOut0_up   <= '0;
            fftOut0_down <= '0;
            fftOut1_up   <= '0;
            fftOut1_down <= '0;
        end else begin
            out_valid <= r_rv;
            out_sof   <= r_rsof;
            if (r_rv) begin
                fftOut0_up   <= w_rdata[r_sel[0]];
                fftOut0_down <= w_rdata[r_sel[1]];
                fftOut1_up   <= w_rdata[r_sel[2]];
                fftOut1_down <= w_rdata[r_sel[3]];
            end
        end
    end

`ifdef FFT_REORDER_ERRFLAG_EN
    logic w_abandon;
    logic w_nosof;

    assign w_abandon = in_valid && in_sof && (r_wstate == W_FILL) && (r_wc != '0);
    assign w_nosof   = in_valid && !in_sof && (r_wstate == W_FILL) && (r_wc == '0);

    always_ff @(posedge clk) begin
        if (rst) err_sticky <= 1'b0;
        else if (w_abandon || w_nosof) err_sticky <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - self-checking bench: frame-level reorder model plus directed literal checks
module tb_fft_reorder;

    localparam int NB = 19;
    localparam int W  = 38;
    localparam int LG = 7;
    localparam int B  = 32;

    typedef struct packed {
        int             t;
        logic           sof;
        logic [4*W-1:0] d;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [4*W-1:0] in_d = '0;
    logic out_valid, out_sof;
    logic [W-1:0] o0, o1, o2, o3;
    logic [4*W-1:0] od;

    logic v3 = 1'b0;
    logic s3 = 1'b0;
    logic [4*W-1:0] d3 = '0;
    logic q_valid, q_sof;
    logic [W-1:0] q0, q1, q2, q3;

`ifdef FFT_REORDER_ERRFLAG_EN
    logic err, err3;
`endif

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  armed = 1'b0;
    ex_t exq[$];
    ex_t e;
    logic [W-1:0] m_buf [128];
    bit  m_fill = 1'b0;
    int  m_cnt = 0;
    bit  m_err = 1'b0;
    logic [4*W-1:0] last = '0;
    int  ce, ce3;

    always #5 clk = ~clk;

    assign od = {o3, o2, o1, o0};

    fft_reorder #(.NBITS(NB), .LOG2N(LG)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .fftIn0_up(in_d[37:0]), .fftIn0_down(in_d[75:38]),
        .fftIn1_up(in_d[113:76]), .fftIn1_down(in_d[151:114]),
        .out_valid(out_valid), .out_sof(out_sof),
        .fftOut0_up(o0), .fftOut0_down(o1), .fftOut1_up(o2), .fftOut1_down(o3)
`ifdef FFT_REORDER_ERRFLAG_EN
        , .err_sticky(err)
`endif
    );

    fft_reorder #(.NBITS(NB), .LOG2N(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_sof(s3),
        .fftIn0_up(d3[37:0]), .fftIn0_down(d3[75:38]),
        .fftIn1_up(d3[113:76]), .fftIn1_down(d3[151:114]),
        .out_valid(q_valid), .out_sof(q_sof),
        .fftOut0_up(q0), .fftOut0_down(q1), .fftOut1_up(q2), .fftOut1_down(q3)
`ifdef FFT_REORDER_ERRFLAG_EN
        , .err_sticky(err3)
`endif
    );

    task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int bitrev7(input int p);
        int r = 0;
        for (int i = 0; i < LG; i++) if (((p >> i) & 1) != 0) r |= 1 << (LG - 1 - i);
        return r;
    endfunction

    // Frame model: stores each accepted lane at its bin, emits a whole frame
    // in bin order starting two edges after the completing beat.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            exq.delete();
            m_fill = 1'b0;
            m_cnt  = 0;
            m_err  = 1'b0;
            last   = '0;
        end else if (in_valid) begin
            if (in_sof) begin
                if (m_fill && m_cnt != 0) m_err = 1'b1;
                m_fill = 1'b1;
                m_cnt  = 0;
            end else if (m_fill && m_cnt == 0) begin
                m_fill = 1'b0;
                m_err  = 1'b1;
            end
            if (m_fill && (in_sof || m_cnt != 0)) begin
                for (int l = 0; l < 4; l++) m_buf[bitrev7(4 * m_cnt + l)] = in_d[l*W +: W];
                m_cnt++;
                if (m_cnt == B) begin
                    for (int j = 0; j < B; j++) begin
                        e.t   = cyc + 2 + j;
                        e.sof = (j == 0);
                        for (int l = 0; l < 4; l++) e.d[l*W +: W] = m_buf[4*j + l];
                        exq.push_back(e);
                    end
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (exq.size() > 0 && exq[0].t == cyc) begin
                chk("beat_valid", out_valid, 1);
                chk("beat_sof", out_sof, exq[0].sof);
                chk("beat_data", od, exq[0].d);
                last = exq[0].d;
                void'(exq.pop_front());
            end else begin
                chk("idle_valid", out_valid, 0);
                chk("hold_data", od, last);
            end
`ifdef FFT_REORDER_ERRFLAG_EN
            chk("err_sticky", err, m_err);
`endif
        end
    end

    task automatic beat(input bit v, input bit s, input int c, input int fr);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        for (int l = 0; l < 4; l++) in_d[l*W +: W] = {NB'(4*c + l), NB'(fr)};
    endtask

    task automatic idle(input int n);
        repeat (n) beat(0, 0, 0, 0);
    endtask

    task automatic send_frame(input int fr, input bit gaps, output int cx);
        int k = 0;
        for (int c = 0; c < B; c++) begin
            if (gaps && (k % 3 == 2)) begin
                beat(0, 0, 0, 0);
                k++;
            end
            beat(1, c == 0, c, fr);
            k++;
        end
        cx = cyc + 1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset_valid", out_valid, 0);
        chk("reset_sof", out_sof, 0);
        chk("reset_data", od, 0);
        rst = 1'b0;
        idle(2);

        send_frame(0, 0, ce);
        idle(1);
        wait_until(ce + 1);
        chk("latency_not_yet", out_valid, 0);
        wait_until(ce + 2);
        chk("f0_b0_valid", out_valid, 1);
        chk("f0_b0_sof", out_sof, 1);
        chk("f0_b0_real", {o0[37:19], o1[37:19], o2[37:19], o3[37:19]},
            {19'd0, 19'd64, 19'd32, 19'd96});
        wait_until(ce + 3);
        chk("f0_b1_sof", out_sof, 0);
        chk("f0_b1_real", {o0[37:19], o1[37:19], o2[37:19], o3[37:19]},
            {19'd16, 19'd80, 19'd48, 19'd112});
        wait_until(ce + 40);

        for (int f = 1; f <= 4; f++) send_frame(f, 0, ce);
        idle(1);
        wait_until(ce + 18);
        chk("f4_imag", o0[18:0], 4);
        wait_until(ce + 40);

        send_frame(5, 1, ce);
        idle(1);
        wait_until(ce + 40);

`ifdef FFT_REORDER_ERRFLAG_EN
        chk("err_clear_before", err, 0);
`endif
        for (int c = 0; c < 10; c++) beat(1, c == 0, c, 6);
        send_frame(6, 0, ce);
        idle(1);
        wait_until(ce + 2);
        chk("f6_b0_lane1", o1, {19'd64, 19'd6});
        wait_until(ce + 40);
`ifdef FFT_REORDER_ERRFLAG_EN
        chk("err_after_abandon", err, 1);
`endif
        beat(1, 0, 0, 9);
        idle(3);

        send_frame(7, 0, ce);
        idle(1);
        wait_until(ce + 7);
        chk("f7_b5_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", od, 0);
        rst = 1'b0;
        idle(40);
        send_frame(8, 0, ce);
        idle(1);
        wait_until(ce + 40);

        @(negedge clk);
        v3 = 1'b1;
        s3 = 1'b1;
        for (int l = 0; l < 4; l++) d3[l*W +: W] = {NB'(l), NB'(0)};
        @(negedge clk);
        s3 = 1'b0;
        for (int l = 0; l < 4; l++) d3[l*W +: W] = {NB'(4 + l), NB'(0)};
        ce3 = cyc + 1;
        @(negedge clk);
        v3 = 1'b0;
        wait_until(ce3 + 2);
        chk("n8_b0_valid", q_valid, 1);
        chk("n8_b0_sof", q_sof, 1);
        chk("n8_b0_real", {q0[37:19], q1[37:19], q2[37:19], q3[37:19]},
            {19'd0, 19'd4, 19'd2, 19'd6});
        wait_until(ce3 + 3);
        chk("n8_b1_sof", q_sof, 0);
        chk("n8_b1_real", {q0[37:19], q1[37:19], q2[37:19], q3[37:19]},
            {19'd1, 19'd5, 19'd3, 19'd7});
        wait_until(ce3 + 4);
        chk("n8_end_valid", q_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
